cfg_loader: RTL and testbench
=============================

# cfg_loader

Writes an initial cell pattern into the inactive Game-of-Life field buffer when a load request (`load_cfg_req_t`) arrives. It writes one cell per cycle through a ready/enable memory write port, then pulses `done` so the update engine swaps to the freshly written field. It sits directly between the request source (buttons/switch decoder) and the double-buffered field memory (`field_t` A/B).

## Interface
- `FIELD_W`, default 32: field width in cells, must be ≥ 3.
- `FIELD_H`, default 16: field height in cells, must be ≥ 3.
- `ADDR_W`, derived localparam = `$clog2(FIELD_W*FIELD_H)`; not overridable.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req` in 2: `load_cfg_req_t` value (`NO_REQ`, `MEM_INIT`, `CFG_1`, `CFG_2`).
- `req_ready` out 1: loader can accept a request.
- `cur_field` in 1: `field_t` currently active, i.e. being displayed or simulated.
- `wr_en` out 1: write request to field memory.
- `wr_field` out 1: `field_t` being written.
- `wr_addr` out ADDR_W: cell address = y*FIELD_W + x.
- `wr_data` out 1: cell value (1 = alive).
- `wr_ready` in 1: memory accepts the write this cycle.
- `busy` out 1: high in WRITE and DONE.
- `done` out 1: single-cycle pulse; `wr_field` now holds the pattern and must become active.

## Operation
- FSM states: IDLE, WRITE, DONE.
- **IDLE:**
  - `req_ready`=1.
  - A request is accepted when `req_valid` && `req` != `NO_REQ`.
  - On accept, latch `req`, latch `wr_field` = ~`cur_field`, clear x/y/addr counters, and go to WRITE.
  - `req_valid` with `NO_REQ` is ignored: no state change, nothing latched.
- **WRITE:**
  - `wr_en`=1, `req_ready`=0.
  - A write completes on a cycle where `wr_en` && `wr_ready`.
  - On completion, x increments. When x wraps from FIELD_W-1 to 0, y increments. `wr_addr` increments by 1.
  - After the write to address FIELD_W*FIELD_H-1 completes, go to DONE.
  - While `wr_ready`=0, `wr_addr`, `wr_data` and `wr_field` hold their values.
- **DONE:** `done`=1 for one cycle, then return to IDLE.
- `wr_data` is a combinational function of the latched request and the current x,y:
  - `MEM_INIT`: 0 for every cell.
  - `CFG_1` (glider): 1 only at (x,y) ∈ {(1,0),(2,1),(0,2),(1,2),(2,2)}; 0 elsewhere.
  - `CFG_2` (checkerboard): 1 iff x[0] ^ y[0] == 0.
- Requests arriving during WRITE or DONE are ignored and not queued.
- `cur_field` is sampled only at accept. Changes to it during WRITE have no effect.

## Timing
- Reset values (asserted immediately, asynchronously):
  - state IDLE
  - `req_ready`=1, `busy`=0, `wr_en`=0, `done`=0
  - `wr_addr`=0, `wr_data`=0, `wr_field`=`FIELD_A`
- Accept at edge N: `wr_en`=1 with `wr_addr`=0 during cycle N+1.
- With `wr_ready` held at 1, the write to address k occurs in cycle N+1+k.
- `done` is high in cycle N+1+CELLS (CELLS = FIELD_W*FIELD_H). `req_ready` returns to 1 in cycle N+2+CELLS.
- Each cycle with `wr_ready`=0 during WRITE adds exactly one cycle to that latency.
- `req_ready`, `busy`, `wr_en` and `done` decode from registered state only. No combinational path from `req_valid` or `wr_ready` to any output.
- Reset mid-WRITE: the FSM returns to IDLE at once and no `done` is issued. The partially written field stays inactive, and the next request restarts from address 0.

## Configuration
- `CFG_LOADER_ASSERT_EN`
- **Defined:** concurrent assertions are compiled in, clocked on `clk` and disabled while `rst_n`=0:
  - `wr_addr` < CELLS whenever `wr_en`.
  - `wr_addr`, `wr_data` and `wr_field` are stable while `wr_en` && !`wr_ready`.
  - `done` is never high on two consecutive cycles.
  - `wr_en` && `req_ready` never holds.
- **Undefined:** no assertions. Functional behaviour is identical.

## Test plan
All scenarios use FIELD_W=8, FIELD_H=4 (CELLS=32).
- **MEM_INIT:** `cur_field`=`FIELD_A`, `wr_ready`=1, `MEM_INIT` accepted at edge N -> 32 writes, addr 0..31, data 0, `wr_field`=`FIELD_B`, `done` in cycle N+33 only.
- **Glider:** `cur_field`=`FIELD_B`, `CFG_1` -> `wr_data`=1 exactly at addrs 1, 10, 16, 17, 18, and 0 at the other 27 writes; `wr_field`=`FIELD_A`.
- **Checkerboard:** `CFG_2` -> `wr_data`=1 at addrs 0,2,4,6,9,11,13,15,16,18,20,22,25,27,29,31; 0 elsewhere.
- **Backpressure:** `wr_ready` alternates 0/1 starting at 0 -> addr/data held on every stalled cycle, 32 distinct completed writes in order, `done` in cycle N+65.
- **Ignored requests:** `req_valid`=1 with `NO_REQ` in IDLE -> no state change. `CFG_1` pulsed during WRITE -> ignored, and the current `MEM_INIT` pattern completes unchanged.
- **Reset mid-op:** `rst_n` driven low while `wr_addr`=12 -> `wr_en`=0, `busy`=0, `req_ready`=1 immediately with no `done`. After release, `CFG_2` restarts at addr 0.

Source files
------------

// File: rtl/cfg_loader.sv
// Game-of-Life pattern loader: writes one cell per cycle into the inactive field, then pulses done.
// Optional CFG_LOADER_ASSERT_EN compiles in protocol assertions on the write port.
module cfg_loader #(
    parameter int unsigned FIELD_W = 32,
    parameter int unsigned FIELD_H = 16,
    localparam int unsigned ADDR_W = $clog2(FIELD_W * FIELD_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [1:0]        req,
    output logic              req_ready,
    input  logic              cur_field,
    output logic              wr_en,
    output logic              wr_field,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CELLS = FIELD_W * FIELD_H;
    localparam int unsigned XW    = $clog2(FIELD_W);
    localparam int unsigned YW    = $clog2(FIELD_H);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [XW-1:0]     X_MAX     = XW'(FIELD_W - 1);

    typedef enum logic [1:0] {
        NO_REQ   = 2'd0,
        MEM_INIT = 2'd1,
        CFG_1    = 2'd2,
        CFG_2    = 2'd3
    } load_cfg_req_t;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDone
    } state_t;

    state_t        state;
    load_cfg_req_t req_l;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            req_l    <= NO_REQ;
            wr_field <= 1'b0;
            wr_addr  <= '0;
            x        <= '0;
            y        <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid && (req != NO_REQ)) begin
                        req_l    <= load_cfg_req_t'(req);
                        wr_field <= ~cur_field;
                        wr_addr  <= '0;
                        x        <= '0;
                        y        <= '0;
                        state    <= StWrite;
                    end
                end
                StWrite: begin
                    if (wr_ready) begin
                        // Counters hold on the final cell so wr_addr never leaves the field.
                        if (wr_addr == LAST_ADDR) begin
                            state <= StDone;
                        end else begin
                            wr_addr <= wr_addr + ADDR_W'(1);
                            if (x == X_MAX) begin
                                x <= '0;
                                y <= y + YW'(1);
                            end else begin
                                x <= x + XW'(1);
                            end
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign req_ready = (state == StIdle);
    assign wr_en     = (state == StWrite);
    assign done      = (state == StDone);
    assign busy      = (state == StWrite) || (state == StDone);

    logic glider_cell;
    assign glider_cell = ((y == YW'(0)) && (x == XW'(1))) ||
                         ((y == YW'(1)) && (x == XW'(2))) ||
                         ((y == YW'(2)) && (x <= XW'(2)));

    always_comb begin
        wr_data = 1'b0;
        case (req_l)
            CFG_1:   wr_data = glider_cell;
            CFG_2:   wr_data = ~(x[0] ^ y[0]);
            default: wr_data = 1'b0;
        endcase
    end

`ifdef CFG_LOADER_ASSERT_EN
    addr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        wr_en |-> (32'(wr_addr) < CELLS));

    stable_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_en && !wr_ready) |=> ($stable(wr_addr) && $stable(wr_data) && $stable(wr_field)));

    done_single_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !done);

    no_write_while_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && req_ready));
`else
    // Assertions not compiled in this build.
`endif

endmodule

// File: tb/tb_cfg_loader.sv
// Scoreboard bench for cfg_loader on an 8x4 field: expected writes queued at request time,
// popped and compared on every completed memory write.
module tb_cfg_loader;

    localparam logic [1:0] NO_REQ   = 2'd0;
    localparam logic [1:0] MEM_INIT = 2'd1;
    localparam logic [1:0] CFG_1    = 2'd2;
    localparam logic [1:0] CFG_2    = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] req;
    logic       req_ready;
    logic       cur_field;
    logic       wr_en;
    logic       wr_field;
    logic [4:0] wr_addr;
    logic       wr_data;
    logic       wr_ready;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [4:0] addr;
        logic       data;
        logic       field;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        checks   = 0;
    int        failures = 0;

    cfg_loader #(
        .FIELD_W(8),
        .FIELD_H(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req       (req),
        .req_ready (req_ready),
        .cur_field (cur_field),
        .wr_en     (wr_en),
        .wr_field  (wr_field),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic model_data(input logic [1:0] r, input int a);
        int x = a % 8;
        int y = a / 8;
        case (r)
            CFG_1:   return (a == 1) || (a == 10) || (a == 16) || (a == 17) || (a == 18);
            CFG_2:   return ((x + y) % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; the request is accepted at the next posedge (edge N).
    task automatic do_load(input logic [1:0] r, input logic cf, input bit stall, input bit inject,
                           input int done_cyc);
        int        writes    = 0;
        int        done_seen = 0;
        sb_entry_t e;
        for (int a = 0; a < 32; a++) begin
            e.addr  = 5'(a);
            e.data  = model_data(r, a);
            e.field = ~cf;
            sb_q.push_back(e);
        end
        req_valid = 1'b1;
        req       = r;
        cur_field = cf;
        wr_ready  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req       = NO_REQ;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            wr_ready = stall ? (c % 2 == 0) : 1'b1;
            if (inject && c == 5) begin
                req_valid = 1'b1;
                req       = CFG_1;
                cur_field = ~cf;
            end
            if (inject && c == 6) begin
                req_valid = 1'b0;
                req       = NO_REQ;
            end
            if (wr_en) check("ready_low_in_write", req_ready, 0);
            if (wr_en && !wr_ready && sb_q.size() != 0) begin
                check("stall_addr", wr_addr, sb_q[0].addr);
                check("stall_data", wr_data, sb_q[0].data);
                check("stall_field", wr_field, sb_q[0].field);
            end
            if (wr_en && wr_ready) begin
                if (sb_q.size() == 0) begin
                    check("extra_write", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                    check("wr_field", wr_field, e.field);
                end
                writes++;
            end
            if (done) begin
                done_seen++;
                check("done_cycle", c, done_cyc);
            end
            if (c == done_cyc) begin
                check("done_high", done, 1);
                check("busy_in_done", busy, 1);
                check("wr_en_in_done", wr_en, 0);
            end
            if (c == done_cyc + 1) begin
                check("ready_back", req_ready, 1);
                check("busy_back", busy, 0);
            end else begin
                @(negedge clk);
            end
        end
        check("done_count", done_seen, 1);
        check("write_count", writes, 32);
        check("sb_empty", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        bit found;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req       = NO_REQ;
        cur_field = 1'b0;
        wr_ready  = 1'b1;
        #3;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_done", done, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_wr_field", wr_field, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // NO_REQ with valid must not be accepted (accepting would latch wr_field=1)
        req_valid = 1'b1;
        req       = NO_REQ;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("noreq_ready", req_ready, 1);
            check("noreq_wr_en", wr_en, 0);
            check("noreq_busy", busy, 0);
            check("noreq_field", wr_field, 0);
        end
        req_valid = 1'b0;

        do_load(MEM_INIT, 1'b0, 1'b0, 1'b0, 33);
        do_load(CFG_1, 1'b1, 1'b0, 1'b0, 33);
        do_load(CFG_2, 1'b0, 1'b0, 1'b0, 33);
        do_load(CFG_1, 1'b0, 1'b1, 1'b0, 65);
        do_load(MEM_INIT, 1'b0, 1'b0, 1'b1, 33);

        // Reset in the middle of a write sequence
        req_valid = 1'b1;
        req       = MEM_INIT;
        cur_field = 1'b0;
        wr_ready  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req       = NO_REQ;
        found     = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (wr_en && wr_addr == 5'd12) found = 1'b1;
            else @(negedge clk);
        end
        check("reach_addr12", found, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", wr_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", req_ready, 1);
        check("midrst_done", done, 0);
        check("midrst_addr", wr_addr, 0);
        check("midrst_field", wr_field, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", req_ready, 1);
        do_load(CFG_2, 1'b1, 1'b0, 1'b0, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
